p2s_sched: RTL and testbench

Scheduler that shares one parallel-to-serial shifter between two display requesters: channel 0 is the LED chain and channel 1 is the auxiliary chain. It detects changed data or a periodic refresh, then arbitrates round-robin. For the winning channel it launches a shift frame and holds the chain-select output so the board-level mux routes the shifter to the correct chain. It then waits on the shifter's busy handshake and applies a guard gap before the next frame.

---
 rtl/p2s_sched.sv | 123 ++++++++++++
 tb/tb_p2s_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_sched.sv
// rtl/p2s_sched.sv - round-robin scheduler sharing one parallel-to-serial shifter between two chains
module p2s_sched #(
   parameter int WIDTH       = 16,
   parameter int REFRESH_CYC = 1000000,
   parameter int BUSY_TO     = 16,
   parameter int GAP         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ch0_data,
   input  logic [WIDTH-1:0] ch1_data,
   input  logic             sh_busy,
   output logic             sh_start,
   output logic [WIDTH-1:0] sh_data,
   output logic             sh_sel,
   output logic [1:0]       sent,
   output logic             err,
   output logic             active
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LAUNCH    = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_GUARD     = 3'd4;

   localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   logic [2:0]       state;
   logic             sel_q;
   logic             rr;
   logic [1:0]       pend;
   logic [1:0]       pend_nxt;
   logic [WIDTH-1:0] last0;
   logic [WIDTH-1:0] last1;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] cur_data;
   logic [RW-1:0]    rcnt;
   logic [TW-1:0]    tcnt;
   logic [GW-1:0]    gcnt;
   logic             err_q;
   logic             tick;
   logic             launch;
   logic             timeout;
   logic             guard_last;
   logic             pick;

   always_comb begin
      tick       = (rcnt == RW'(REFRESH_CYC - 1));
      launch     = (state == S_LAUNCH);
      timeout    = (state == S_WAIT_BUSY) && !sh_busy && (tcnt == TW'(BUSY_TO - 1));
      guard_last = (state == S_GUARD) && (gcnt == GW'(GAP - 1));
      cur_data   = sel_q ? ch1_data : ch0_data;
      pick       = (pend == 2'b11) ? ~rr : pend[1];
      // The launching channel captures its data this cycle, so a same-cycle set never differs from it: clear wins.
      pend_nxt[0] = (launch && !sel_q) ? 1'b0
                  : (pend[0] | (ch0_data != last0) | tick | (timeout && !sel_q));
      pend_nxt[1] = (launch && sel_q) ? 1'b0
                  : (pend[1] | (ch1_data != last1) | tick | (timeout && sel_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         sel_q  <= 1'b0;
         rr     <= 1'b1;
         pend   <= 2'b11;
         last0  <= '0;
         last1  <= '0;
         data_q <= '0;
         rcnt   <= '0;
         tcnt   <= '0;
         gcnt   <= '0;
         err_q  <= 1'b0;
      end else begin
         rcnt  <= tick ? '0 : rcnt + 1'b1;
         pend  <= pend_nxt;
         err_q <= timeout;
         case (state)
            S_IDLE: begin
               if (pend != 2'b00) begin
                  sel_q <= pick;
                  state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               data_q <= cur_data;
               if (sel_q) last1 <= ch1_data;
               else       last0 <= ch0_data;
               rr    <= sel_q;
               tcnt  <= '0;
               state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (sh_busy)      state <= S_WAIT_DONE;
               else if (timeout) state <= S_IDLE;
               else              tcnt  <= tcnt + 1'b1;
            end
            S_WAIT_DONE: begin
               if (!sh_busy) begin
                  gcnt  <= '0;
                  state <= S_GUARD;
               end
            end
            S_GUARD: begin
               if (guard_last) state <= S_IDLE;
               else            gcnt  <= gcnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sh_start = launch;
   assign sh_data  = data_q;
   assign sh_sel   = sel_q;
   assign sent     = guard_last ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign err      = err_q;
   assign active   = (state != S_IDLE);

endmodule

// File: tb/tb_p2s_sched.sv
// tb/tb_p2s_sched.sv - directed bench for p2s_sched with bench shifter models
module tb_p2s_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ch0_data = 16'h0000;
   logic [15:0] ch1_data = 16'h0000;
   logic [15:0] b_ch0 = 16'h3C3C;
   logic [15:0] b_ch1 = 16'hC3C3;
   logic        no_busy = 1'b0;

   logic        a_busy, a_start, a_sel, a_err, a_active;
   logic [15:0] a_data;
   logic [1:0]  a_sent;
   logic [4:0]  a_rem;
   logic        b_busy, b_start, b_sel, b_err, b_active;
   logic [15:0] b_data;
   logic [1:0]  b_sent;
   logic [4:0]  b_rem;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   int          l_n = 0, s_n = 0, e_n = 0, b_n = 0;
   int          l_cyc [64];
   logic        l_sel [64];
   logic [15:0] l_data[64];
   int          s_cyc [64];
   logic [1:0]  s_val [64];
   int          e_cyc [64];
   int          b_cyc [64];
   logic        b_selq[64];
   logic [15:0] b_dat [64];
   int          sel_viol = 0, data_viol = 0;
   logic        prev_start = 1'b0, prev_sel = 1'b0, b_prev_start = 1'b0;
   logic [15:0] prev_data = 16'h0000;

   p2s_sched #(.WIDTH(16), .REFRESH_CYC(5000), .BUSY_TO(16), .GAP(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .ch0_data(ch0_data), .ch1_data(ch1_data),
      .sh_busy(a_busy), .sh_start(a_start), .sh_data(a_data), .sh_sel(a_sel),
      .sent(a_sent), .err(a_err), .active(a_active));

   p2s_sched #(.WIDTH(16), .REFRESH_CYC(100), .BUSY_TO(16), .GAP(4)) u_ref (
      .clk(clk), .rst_n(rst_n), .ch0_data(b_ch0), .ch1_data(b_ch1),
      .sh_busy(b_busy), .sh_start(b_start), .sh_data(b_data), .sh_sel(b_sel),
      .sent(b_sent), .err(b_err), .active(b_active));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shifter models: busy rises the cycle after sh_start, 20 cycles (A) or 5 cycles (B) long.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_busy <= 1'b0; a_rem <= '0;
      end else if (a_start && !no_busy) begin
         a_busy <= 1'b1; a_rem <= 5'd19;
      end else if (a_busy) begin
         if (a_rem == 0) a_busy <= 1'b0;
         else            a_rem  <= a_rem - 1'b1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_busy <= 1'b0; b_rem <= '0;
      end else if (b_start) begin
         b_busy <= 1'b1; b_rem <= 5'd4;
      end else if (b_busy) begin
         if (b_rem == 0) b_busy <= 1'b0;
         else            b_rem  <= b_rem - 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_start && l_n > 0) l_data[l_n-1] = a_data;
         if (a_start && l_n < 64) begin l_sel[l_n] = a_sel; l_cyc[l_n] = cyc; l_n++; end
         if (a_sent != 2'b00 && s_n < 64) begin s_val[s_n] = a_sent; s_cyc[s_n] = cyc; s_n++; end
         if (a_err && e_n < 64) begin e_cyc[e_n] = cyc; e_n++; end
         if (a_sel != prev_sel && !a_start) sel_viol++;
         if (a_data != prev_data && !prev_start) data_viol++;
         prev_start = a_start; prev_sel = a_sel; prev_data = a_data;
         if (b_prev_start && b_n > 0) b_dat[b_n-1] = b_data;
         if (b_start && b_n < 64) begin b_selq[b_n] = b_sel; b_cyc[b_n] = cyc; b_n++; end
         b_prev_start = b_start;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_quiet(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 10 && n < 600) begin
         @(posedge clk); #1;
         n++;
         if (a_active) quiet = 0;
         else          quiet++;
      end
      check({tag, "_quiet"}, 32'(quiet >= 10), 1);
   endtask

   task automatic wait_launch(input int base, input string tag);
      int n = 0;
      while (l_n <= base && n < 100) begin
         @(posedge clk); n++;
      end
      check({tag, "_launch_seen"}, 32'(l_n > base), 1);
   endtask

   initial begin
      int base, sbase;
      int n;
      logic seen;

      repeat (3) @(posedge clk);
      #1;
      check("rst_start",  a_start,  0);
      check("rst_sel",    a_sel,    0);
      check("rst_data",   a_data,   0);
      check("rst_sent",   a_sent,   0);
      check("rst_err",    a_err,    0);
      check("rst_active", a_active, 0);
      @(negedge clk); rst_n = 1'b1;

      // Both channels pend out of reset; ch0 wins the first tie.
      wait_quiet("t1");
      check("t1_count", l_n, 2);
      check("t1_sel0",  l_sel[0], 0);
      check("t1_sel1",  l_sel[1], 1);
      check("t1_data0", l_data[0], 16'h0000);
      check("t1_data1", l_data[1], 16'h0000);
      check("t1_sent0", s_val[0], 2'b01);
      check("t1_sent1", s_val[1], 2'b10);
      check("t1_space", l_cyc[1] - l_cyc[0], 27);
      repeat (50) @(posedge clk);
      check("t1_no_more", l_n, 2);

      base = l_n; sbase = s_n;
      @(negedge clk); ch1_data = 16'hA5A5;
      wait_quiet("t2");
      check("t2_count", l_n - base, 1);
      check("t2_sel",   l_sel[base], 1);
      check("t2_data",  l_data[base], 16'hA5A5);
      check("t2_sent",  s_val[sbase], 2'b10);
      check("t2_sent_t", s_cyc[sbase] - l_cyc[base], 25);

      // A ch0 value change mid-frame is sent in a follow-up frame.
      base = l_n;
      @(negedge clk); ch0_data = 16'h1234;
      wait_launch(base, "t4");
      repeat (5) @(negedge clk);
      ch0_data = 16'h5678;
      wait_quiet("t4");
      check("t4_count", l_n - base, 2);
      check("t4_data0", l_data[base], 16'h1234);
      check("t4_data1", l_data[base+1], 16'h5678);
      check("t4_sel0",  l_sel[base], 0);
      check("t4_sel1",  l_sel[base+1], 0);
      check("t4_space", l_cyc[base+1] - l_cyc[base], 27);

      // rr now points at ch0, so a simultaneous change launches ch1 first.
      base = l_n;
      @(negedge clk); ch0_data = 16'hAAAA; ch1_data = 16'h5555;
      wait_quiet("t3");
      check("t3_count", l_n - base, 2);
      check("t3_sel0",  l_sel[base], 1);
      check("t3_data0", l_data[base], 16'h5555);
      check("t3_sel1",  l_sel[base+1], 0);
      check("t3_data1", l_data[base+1], 16'hAAAA);

      base = l_n; sbase = s_n;
      no_busy = 1'b1;
      @(negedge clk); ch0_data = 16'hBEEF;
      n = 0;
      while (e_n == 0 && n < 100) begin @(posedge clk); n++; end
      check("t5_err_seen", 32'(e_n > 0), 1);
      @(negedge clk); no_busy = 1'b0;
      wait_quiet("t5");
      check("t5_err_count", e_n, 1);
      check("t5_err_t",  e_cyc[0] - l_cyc[base], 17);
      check("t5_count",  l_n - base, 2);
      check("t5_retry_t", l_cyc[base+1] - l_cyc[base], 18);
      check("t5_sel",    l_sel[base+1], 0);
      check("t5_data0",  l_data[base], 16'hBEEF);
      check("t5_data1",  l_data[base+1], 16'hBEEF);
      check("t5_sent",   s_n - sbase, 1);

      n = 0;
      while (b_n < 4 && n < 400) begin @(posedge clk); n++; end
      check("r_count", 32'(b_n >= 4), 1);
      check("r_sel0", b_selq[0], 0);
      check("r_sel1", b_selq[1], 1);
      check("r_sel2", b_selq[2], 0);
      check("r_sel3", b_selq[3], 1);
      check("r_pair", b_cyc[1] - b_cyc[0], 12);
      check("r_per0", b_cyc[2] - b_cyc[0], 100);
      check("r_per1", b_cyc[3] - b_cyc[1], 100);
      check("r_data", b_dat[2], 16'h3C3C);

      check("sel_stable",  sel_viol, 0);
      check("data_stable", data_viol, 0);

      // Assert reset inside a ch1 LAUNCH cycle, between clock edges.
      @(negedge clk); ch1_data = 16'h0F0F;
      seen = 1'b0; n = 0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (a_start) seen = 1'b1;
      end
      check("ar_launch_seen", seen, 1);
      check("ar_pre_sel", a_sel, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_start",  a_start,  0);
      check("ar_sel",    a_sel,    0);
      check("ar_data",   a_data,   0);
      check("ar_sent",   a_sent,   0);
      check("ar_err",    a_err,    0);
      check("ar_active", a_active, 0);
      check("ar_b_active", b_active, 0);
      check("ar_b_data", b_data, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
